// File: rtl/nway_cache_control.sv
// nway_cache_control: WAYS-way cache controller with per-set tree PLRU; NWAY_CACHE_PERF_EN builds hit/miss/writeback counters
module nway_cache_control #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read_i,
  input  logic                    mem_write_i,
  input  logic [$clog2(SETS)-1:0] set_idx_i,
  input  logic [WAYS-1:0]         hit_way_i,
  input  logic [WAYS-1:0]         valid_way_i,
  input  logic [WAYS-1:0]         dirty_way_i,
  input  logic                    pmem_resp_i,
  output logic                    mem_resp_o,
  output logic                    pmem_read_o,
  output logic                    pmem_write_o,
  output logic                    pmem_addr_sel_o,
  output logic                    data_in_sel_o,
  output logic [WAYS-1:0]         data_we_o,
  output logic [WAYS-1:0]         ld_tag_o,
  output logic [WAYS-1:0]         ld_valid_o,
  output logic [WAYS-1:0]         ld_dirty_o,
  output logic                    valid_in_o,
  output logic                    dirty_in_o,
  output logic [$clog2(WAYS)-1:0] victim_way_o,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o,
  output logic [31:0]             wb_count_o
);
  localparam int WW = $clog2(WAYS);
  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] victim_q, victim_d, hit_idx, free_idx, lru_idx, lru_n, upd_n;
  logic [WAYS-2:0] plru_q [SETS];
  logic [WAYS-2:0] plru_upd;
  logic [WAYS-1:0] vmask;
  logic free_any, hit, plru_we;
  assign hit = |hit_way_i;
  assign vmask = WAYS'(1) << victim_q;
  assign victim_way_o = victim_q;
  // Encode the hit way and find the lowest-index invalid way
  always_comb begin
    hit_idx = '0;
    free_idx = '0;
    free_any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_way_i[i]) hit_idx = WW'(i);
      if (!valid_way_i[i]) begin
        free_idx = WW'(i);
        free_any = 1'b1;
      end
    end
  end
  // Walk the tree for the PLRU victim and build the updated tree for the hit way
  always_comb begin
    lru_idx = '0;
    lru_n = '0;
    upd_n = '0;
    plru_upd = plru_q[set_idx_i];
    for (int l = 0; l < WW; l++) begin
      lru_idx[WW-1-l] = plru_q[set_idx_i][lru_n];
      lru_n = WW'(2 * int'(lru_n) + 1 + int'(plru_q[set_idx_i][lru_n]));
      plru_upd[upd_n] = ~hit_idx[WW-1-l];
      upd_n = WW'(2 * int'(upd_n) + 1 + int'(hit_idx[WW-1-l]));
    end
  end
  // Next state and Mealy outputs; reset forces every output to its default
  always_comb begin
    state_d = state_q;
    victim_d = victim_q;
    plru_we = 1'b0;
    mem_resp_o = 1'b0;
    pmem_read_o = 1'b0;
    pmem_write_o = 1'b0;
    pmem_addr_sel_o = 1'b1;
    data_in_sel_o = 1'b1;
    data_we_o = '0;
    ld_tag_o = '0;
    ld_valid_o = '0;
    ld_dirty_o = '0;
    valid_in_o = 1'b0;
    dirty_in_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: state_d = (mem_read_i || mem_write_i) ? CHECK : IDLE;
        CHECK: begin
          if (hit) begin
            mem_resp_o = 1'b1;
            plru_we = 1'b1;
            state_d = IDLE;
            data_we_o = mem_write_i ? hit_way_i : '0;
            ld_dirty_o = mem_write_i ? hit_way_i : '0;
            dirty_in_o = mem_write_i;
          end else begin
            victim_d = free_any ? free_idx : lru_idx;
            state_d = (valid_way_i[victim_d] && dirty_way_i[victim_d]) ? WB : FILL;
          end
        end
        WB: begin
          pmem_write_o = 1'b1;
          pmem_addr_sel_o = 1'b0;
          ld_dirty_o = pmem_resp_i ? vmask : '0;
          state_d = pmem_resp_i ? FILL : WB;
        end
        FILL: begin
          pmem_read_o = 1'b1;
          data_in_sel_o = 1'b0;
          data_we_o = pmem_resp_i ? vmask : '0;
          ld_tag_o = pmem_resp_i ? vmask : '0;
          ld_valid_o = pmem_resp_i ? vmask : '0;
          ld_dirty_o = pmem_resp_i ? vmask : '0;
          valid_in_o = pmem_resp_i;
          state_d = pmem_resp_i ? CHECK : FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // FSM state, registered victim and PLRU trees
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[set_idx_i] <= plru_upd;
    end
  end
`ifdef NWAY_CACHE_PERF_EN
  logic [31:0] hit_q, miss_q, wb_q;
  logic missed_q;
  // Count first-try hits, misses and writebacks; missed_q suppresses the post-fill hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
      miss_q <= '0;
      wb_q <= '0;
      missed_q <= 1'b0;
    end else if (state_q == CHECK) begin
      if (hit) begin
        hit_q <= hit_q + 32'(!missed_q);
        missed_q <= 1'b0;
      end else begin
        miss_q <= miss_q + 32'd1;
        wb_q <= wb_q + 32'(state_d == WB);
        missed_q <= 1'b1;
      end
    end
  end
  assign hit_count_o = hit_q;
  assign miss_count_o = miss_q;
  assign wb_count_o = wb_q;
`else
  assign hit_count_o = '0;
  assign miss_count_o = '0;
  assign wb_count_o = '0;
`endif
endmodule

// File: tb/tb_nway_cache_control.sv
// tb_nway_cache_control: directed and randomized checks of nway_cache_control against a tree-PLRU reference model
module tb_nway_cache_control;
  localparam int WAYS = 4;
  localparam int SETS = 8;
`ifdef NWAY_CACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [22:0] IDLE_V = 23'h0C0000;
  typedef struct packed {
    logic pr;
    logic [3:0] hw;
    logic [22:0] out;
    logic chkv;
    logic [1:0] vic;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1, mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
  logic [2:0] set_idx = '0;
  logic [3:0] hit_way = '0, valid_way = '0, dirty_way = '0;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, valid_in, dirty_in;
  logic [3:0] data_we, ld_tag, ld_valid, ld_dirty;
  logic [1:0] victim_way;
  logic [31:0] hit_count, miss_count, wb_count;
  logic [22:0] act;
  int checks = 0, errors = 0;
  bit plru_m [SETS][WAYS-1];
  int hit_m = 0, miss_m = 0, wb_m = 0;
  bit missed_m = 1'b0;
  always #5 clk = ~clk;
  assign act = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, data_we, ld_tag, ld_valid, ld_dirty, valid_in, dirty_in};
  nway_cache_control #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write), .set_idx_i(set_idx),
    .hit_way_i(hit_way), .valid_way_i(valid_way), .dirty_way_i(dirty_way), .pmem_resp_i(pmem_resp),
    .mem_resp_o(mem_resp), .pmem_read_o(pmem_read), .pmem_write_o(pmem_write), .pmem_addr_sel_o(pmem_addr_sel),
    .data_in_sel_o(data_in_sel), .data_we_o(data_we), .ld_tag_o(ld_tag), .ld_valid_o(ld_valid), .ld_dirty_o(ld_dirty),
    .valid_in_o(valid_in), .dirty_in_o(dirty_in), .victim_way_o(victim_way),
    .hit_count_o(hit_count), .miss_count_o(miss_count), .wb_count_o(wb_count)
  );
  function automatic logic [22:0] ev(input int resp, rd, wr, asel, dsel, we, tag, vld, drt, vin, din);
    return {1'(resp), 1'(rd), 1'(wr), 1'(asel), 1'(dsel), 4'(we), 4'(tag), 4'(vld), 4'(drt), 1'(vin), 1'(din)};
  endfunction
  function automatic int m_victim(input int s);
    int lo, sz, node;
    lo = 0;
    sz = WAYS;
    while (sz > 1) begin
      node = WAYS / sz - 1 + lo / sz;
      sz = sz / 2;
      if (plru_m[s][node]) lo += sz;
    end
    return lo;
  endfunction
  task automatic m_touch(input int s, input int w);
    int lo, sz, node;
    lo = 0;
    sz = WAYS;
    while (sz > 1) begin
      node = WAYS / sz - 1 + lo / sz;
      sz = sz / 2;
      plru_m[s][node] = (w < lo + sz);
      if (w >= lo + sz) lo += sz;
    end
  endtask
  task automatic m_hit(input int s, input int w);
    m_touch(s, w);
    if (!missed_m) hit_m++;
    missed_m = 1'b0;
  endtask
  task automatic m_reset();
    foreach (plru_m[s, n]) plru_m[s][n] = 1'b0;
    hit_m = 0;
    miss_m = 0;
    wb_m = 0;
    missed_m = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL reset_outputs got=%h want=%h", act, IDLE_V); end
    checks++;
    if (victim_way !== 2'd0 || hit_count !== 0 || miss_count !== 0 || wb_count !== 0) begin
      errors++; $display("FAIL reset_regs victim=%0d hit=%0d miss=%0d wb=%0d want all 0", victim_way, hit_count, miss_count, wb_count);
    end
    tick();
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL reset_release got=%h want=%h", act, IDLE_V); end
    tick();
  endtask
  task automatic test_read_hit();
    set_idx = 3'd3; hit_way = 4'b0100; valid_way = 4'hF; dirty_way = 4'h0; mem_read = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL rd_hit_idle got=%h want=%h", act, IDLE_V); end
    tick();
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL rd_hit_resp got=%h want=%h", act, ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); end
    m_hit(3, 2);
    tick();
    mem_read = 1'b0;
    hit_way = 4'h0;
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL rd_hit_after got=%h want=%h", act, IDLE_V); end
    tick();
  endtask
  task automatic test_write_hit();
    set_idx = 3'd1; hit_way = 4'b0010; valid_way = 4'hF; dirty_way = 4'h0; mem_write = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 2, 0, 0, 2, 0, 1)) begin errors++; $display("FAIL wr_hit got=%h want=%h", act, ev(1, 0, 0, 1, 1, 2, 0, 0, 2, 0, 1)); end
    m_hit(1, 1);
    tick();
    mem_write = 1'b0;
    hit_way = 4'h0;
    tick();
  endtask
  task automatic test_read_miss();
    set_idx = 3'd0; hit_way = 4'h0; valid_way = 4'b1011; dirty_way = 4'h0; mem_read = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL miss_check got=%h want=%h", act, IDLE_V); end
    miss_m++;
    missed_m = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (act !== ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0) || victim_way !== 2'd2) begin
        errors++; $display("FAIL miss_fill_wait got=%h victim=%0d want=%h victim=2", act, victim_way, ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      tick();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== ev(0, 1, 0, 1, 0, 4, 4, 4, 4, 1, 0)) begin errors++; $display("FAIL miss_fill_resp got=%h want=%h", act, ev(0, 1, 0, 1, 0, 4, 4, 4, 4, 1, 0)); end
    tick();
    pmem_resp = 1'b0; hit_way = 4'b0100; valid_way = 4'hF;
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL miss_recheck got=%h want=%h", act, ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); end
    m_hit(0, 2);
    tick();
    mem_read = 1'b0; hit_way = 4'h0;
    @(negedge clk);
    checks++;
    if (miss_count !== (PERF ? miss_m : 0) || hit_count !== (PERF ? hit_m : 0)) begin
      errors++; $display("FAIL miss_counts hit=%0d miss=%0d want hit=%0d miss=%0d", hit_count, miss_count, PERF ? hit_m : 0, PERF ? miss_m : 0);
    end
    tick();
  endtask
  task automatic test_dirty_wb();
    int v;
    set_idx = 3'd2; hit_way = 4'h0; valid_way = 4'hF; dirty_way = 4'hF; mem_write = 1'b1;
    v = m_victim(2);
    tick();
    miss_m++; wb_m++; missed_m = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (act !== ev(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0) || victim_way !== 2'(v) || wb_count !== (PERF ? wb_m : 0)) begin
        errors++; $display("FAIL wb_wait got=%h victim=%0d wb=%0d want=%h victim=%0d wb=%0d", act, victim_way, wb_count, ev(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), v, PERF ? wb_m : 0);
      end
      tick();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== ev(0, 0, 1, 0, 1, 0, 0, 0, 1 << v, 0, 0)) begin errors++; $display("FAIL wb_resp got=%h want=%h", act, ev(0, 0, 1, 0, 1, 0, 0, 0, 1 << v, 0, 0)); end
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL wb_fill got=%h want=%h", act, ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); end
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; hit_way = 4'(1 << v);
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 1 << v, 0, 0, 1 << v, 0, 1)) begin errors++; $display("FAIL wb_recheck got=%h want=%h", act, ev(1, 0, 0, 1, 1, 1 << v, 0, 0, 1 << v, 0, 1)); end
    m_hit(2, v);
    tick();
    mem_write = 1'b0; hit_way = 4'h0;
    tick();
  endtask
  task automatic test_rst_mid_fill();
    set_idx = 3'd5; hit_way = 4'h0; valid_way = 4'h0; dirty_way = 4'h0; mem_read = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin errors++; $display("FAIL rstfill_fill got=%b want=1", pmem_read); end
    tick();
    rst = 1'b1; pmem_resp = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== IDLE_V) begin errors++; $display("FAIL rstfill_abandon got=%h want=%h", act, IDLE_V); end
    tick();
    rst = 1'b0; pmem_resp = 1'b0;
    m_reset();
    @(negedge clk);
    checks++;
    if (act !== IDLE_V || victim_way !== 2'd0 || miss_count !== 0) begin
      errors++; $display("FAIL rstfill_idle got=%h victim=%0d miss=%0d want=%h victim=0 miss=0", act, victim_way, miss_count, IDLE_V);
    end
    mem_read = 1'b1; hit_way = 4'b0001; valid_way = 4'hF;
    tick();
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL rstfill_next got=%h want=%h", act, ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); end
    m_hit(5, 0);
    tick();
    mem_read = 1'b0; hit_way = 4'h0;
    tick();
  endtask
  task automatic test_stray_resp();
    pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (act !== IDLE_V) begin errors++; $display("FAIL stray_idle got=%h want=%h", act, IDLE_V); end
      tick();
    end
    pmem_resp = 1'b0; set_idx = 3'd6; hit_way = 4'b1000; mem_read = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (act !== ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL stray_then_hit got=%h want=%h", act, ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); end
    m_hit(6, 3);
    tick();
    mem_read = 1'b0; hit_way = 4'h0;
    @(negedge clk);
    checks++;
    if (hit_count !== (PERF ? hit_m : 0) || wb_count !== (PERF ? wb_m : 0)) begin
      errors++; $display("FAIL stray_counts hit=%0d wb=%0d want hit=%0d wb=%0d", hit_count, wb_count, PERF ? hit_m : 0, PERF ? wb_m : 0);
    end
    tick();
  endtask
  task automatic test_random();
    cyc_t q[$];
    cyc_t c;
    int s, w, v, n, wr, vm;
    for (int t = 0; t < 60; t++) begin
      s = $urandom_range(0, SETS - 1);
      w = $urandom_range(0, WAYS - 1);
      wr = $urandom_range(0, 1);
      set_idx = 3'(s);
      mem_write = 1'(wr);
      mem_read = wr != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      valid_way = $urandom_range(0, 1) != 0 ? 4'hF : 4'($urandom);
      dirty_way = 4'($urandom);
      q.push_back('{1'($urandom_range(0, 1)), 4'h0, IDLE_V, 1'b0, 2'd0});
      if ($urandom_range(0, 2) != 0) begin
        vm = 1 << w;
        q.push_back('{1'($urandom_range(0, 1)), 4'(vm), ev(1, 0, 0, 1, 1, wr != 0 ? vm : 0, 0, 0, wr != 0 ? vm : 0, 0, wr), 1'b0, 2'd0});
        m_hit(s, w);
      end else begin
        v = m_victim(s);
        for (int i = WAYS - 1; i >= 0; i--) if (!valid_way[i]) v = i;
        vm = 1 << v;
        miss_m++;
        missed_m = 1'b1;
        q.push_back('{1'($urandom_range(0, 1)), 4'h0, IDLE_V, 1'b0, 2'd0});
        if (valid_way[v] && dirty_way[v]) begin
          wb_m++;
          n = $urandom_range(0, 3);
          repeat (n) q.push_back('{1'b0, 4'h0, ev(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 2'(v)});
          q.push_back('{1'b1, 4'h0, ev(0, 0, 1, 0, 1, 0, 0, 0, vm, 0, 0), 1'b1, 2'(v)});
        end
        n = $urandom_range(0, 3);
        repeat (n) q.push_back('{1'b0, 4'h0, ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 2'(v)});
        q.push_back('{1'b1, 4'h0, ev(0, 1, 0, 1, 0, vm, vm, vm, vm, 1, 0), 1'b1, 2'(v)});
        q.push_back('{1'($urandom_range(0, 1)), 4'(vm), ev(1, 0, 0, 1, 1, wr != 0 ? vm : 0, 0, 0, wr != 0 ? vm : 0, 0, wr), 1'b1, 2'(v)});
        m_hit(s, v);
      end
      while (q.size() > 0) begin
        c = q.pop_front();
        pmem_resp = c.pr;
        hit_way = c.hw;
        @(negedge clk);
        checks++;
        if (act !== c.out) begin errors++; $display("FAIL rand_outputs txn=%0d got=%h want=%h", t, act, c.out); end
        if (c.chkv) begin
          checks++;
          if (victim_way !== c.vic) begin errors++; $display("FAIL rand_victim txn=%0d got=%0d want=%0d", t, victim_way, c.vic); end
        end
        tick();
      end
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; hit_way = 4'h0;
    end
    @(negedge clk);
    checks++;
    if (hit_count !== (PERF ? hit_m : 0) || miss_count !== (PERF ? miss_m : 0) || wb_count !== (PERF ? wb_m : 0)) begin
      errors++; $display("FAIL rand_counts hit=%0d miss=%0d wb=%0d want hit=%0d miss=%0d wb=%0d", hit_count, miss_count, wb_count, PERF ? hit_m : 0, PERF ? miss_m : 0, PERF ? wb_m : 0);
    end
    tick();
  endtask
  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_read_miss();
    test_dirty_wb();
    test_rst_mid_fill();
    test_stray_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
